// File: rtl/halut_pkg.sv
// rtl/halut_pkg.sv - shared HALUT defaults, loader FSM state and helpers
package halut_pkg;

    localparam int K             = 16;
    localparam int C             = 32;
    localparam int M             = 32;
    localparam int DecoderUnits  = 16;
    localparam int DataTypeWidth = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_ENC = 2'd1,
        LOAD_DEC = 2'd2,
        DONE     = 2'd3
    } halut_loader_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/halut_loader_addr_gen.sv
// rtl/halut_loader_addr_gen.sv - maps flat beat count to unit / column / address
module halut_loader_addr_gen #(
    parameter int CntW         = 14,
    parameter int EncSpan      = 128,
    parameter int DecSpan      = 512,
    parameter int DecoderUnits = 16,
    parameter int UnitW        = 2,
    parameter int MW           = 4,
    parameter int AddrW        = 9
) (
    input  logic [CntW-1:0]  cnt_i,
    input  logic             mode_i,
    output logic [UnitW-1:0] unit_o,
    output logic [MW-1:0]    m_o,
    output logic [AddrW-1:0] addr_o
);

    // Integer arithmetic keeps the span constants from overflowing CntW.
    int c;

    always_comb begin
        c = int'(cnt_i);
        if (mode_i) begin
            unit_o = UnitW'(c / (DecSpan * DecoderUnits));
            m_o    = MW'((c / DecSpan) % DecoderUnits);
            addr_o = AddrW'(c % DecSpan);
        end else begin
            unit_o = UnitW'(c / EncSpan);
            m_o    = '0;
            addr_o = AddrW'(c % EncSpan);
        end
    end

endmodule

// File: rtl/halut_matmul_loader.sv
// rtl/halut_matmul_loader.sv - streams encoder thresholds / decoder LUTs into unit memories (opt. HALUT_LOADER_ABORT_EN)
module halut_matmul_loader #(
    parameter int K             = halut_pkg::K,
    parameter int C             = halut_pkg::C,
    parameter int M             = halut_pkg::M,
    parameter int DecoderUnits  = halut_pkg::DecoderUnits,
    parameter int DataTypeWidth = halut_pkg::DataTypeWidth,
    parameter int EncUnits      = 4,
    parameter int EncDataWidth  = 16,
    localparam int DecUnitsX    = M / DecoderUnits,
    localparam int CPerEncUnit  = C / EncUnits,
    localparam int LoadWidth    = halut_pkg::max_int(EncDataWidth, DataTypeWidth),
    localparam int EncAW        = $clog2(CPerEncUnit * K),
    localparam int DecMW        = $clog2(DecoderUnits),
    localparam int DecAW        = $clog2(C * K)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
`ifdef HALUT_LOADER_ABORT_EN
    input  logic                     abort_i,
`endif
    input  logic                     start_i,
    input  logic                     mode_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [LoadWidth-1:0]     in_data_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [EncAW-1:0]         waddr_enc_o [EncUnits],
    output logic [EncDataWidth-1:0]  wdata_enc_o [EncUnits],
    output logic                     we_enc_o    [EncUnits],
    output logic [DecMW-1:0]         m_addr_dec_o[DecUnitsX],
    output logic [DecAW-1:0]         waddr_dec_o [DecUnitsX],
    output logic [DataTypeWidth-1:0] wdata_dec_o [DecUnitsX],
    output logic                     we_dec_o    [DecUnitsX]
);
    import halut_pkg::*;

    localparam int CntW  = $clog2(M * C * K);
    localparam int UnitW = max_int(1, max_int($clog2(EncUnits), $clog2(DecUnitsX)));
    localparam logic [CntW-1:0] EncLast = CntW'(EncUnits * CPerEncUnit * K - 1);
    localparam logic [CntW-1:0] DecLast = CntW'(M * C * K - 1);

    halut_loader_state_e state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                beat, last_beat, abort, dec_sel;
    logic [UnitW-1:0]    unit;
    logic [DecMW-1:0]    m_idx;
    logic [DecAW-1:0]    addr;

    logic [EncAW-1:0]         waddr_enc_q [EncUnits];
    logic [EncDataWidth-1:0]  wdata_enc_q [EncUnits];
    logic                     we_enc_q    [EncUnits];
    logic [DecMW-1:0]         m_addr_dec_q[DecUnitsX];
    logic [DecAW-1:0]         waddr_dec_q [DecUnitsX];
    logic [DataTypeWidth-1:0] wdata_dec_q [DecUnitsX];
    logic                     we_dec_q    [DecUnitsX];

`ifdef HALUT_LOADER_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    assign dec_sel   = (state_q == LOAD_DEC);
    assign beat      = in_valid_i && in_ready_o;
    assign last_beat = beat && (cnt_q == (dec_sel ? DecLast : EncLast));

    halut_loader_addr_gen #(
        .CntW(CntW), .EncSpan(CPerEncUnit * K), .DecSpan(C * K),
        .DecoderUnits(DecoderUnits), .UnitW(UnitW), .MW(DecMW), .AddrW(DecAW)
    ) u_addr_gen (
        .cnt_i(cnt_q), .mode_i(dec_sel), .unit_o(unit), .m_o(m_idx), .addr_o(addr)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start_i) state_d = mode_i ? LOAD_DEC : LOAD_ENC;
            LOAD_ENC,
            LOAD_DEC: begin
                if (abort)          state_d = IDLE;
                else if (last_beat) state_d = DONE;
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        cnt_d = beat ? cnt_q + CntW'(1) : cnt_q;
        if (state_d == IDLE || state_d == DONE) cnt_d = '0;
    end

    always_comb begin
        in_ready_o = ((state_q == LOAD_ENC) || (state_q == LOAD_DEC)) && !abort;
        busy_o     = (state_q != IDLE);
        done_o     = (state_q == DONE);
    end

    // One registered write per accepted beat; addresses/data hold between writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int u = 0; u < EncUnits; u++) begin
                we_enc_q[u]    <= 1'b0;
                waddr_enc_q[u] <= '0;
                wdata_enc_q[u] <= '0;
            end
            for (int x = 0; x < DecUnitsX; x++) begin
                we_dec_q[x]     <= 1'b0;
                m_addr_dec_q[x] <= '0;
                waddr_dec_q[x]  <= '0;
                wdata_dec_q[x]  <= '0;
            end
        end else begin
            for (int u = 0; u < EncUnits; u++) begin
                we_enc_q[u] <= beat && !dec_sel && (unit == UnitW'(u));
                if (beat && !dec_sel && (unit == UnitW'(u))) begin
                    waddr_enc_q[u] <= addr[EncAW-1:0];
                    wdata_enc_q[u] <= in_data_i[EncDataWidth-1:0];
                end
            end
            for (int x = 0; x < DecUnitsX; x++) begin
                we_dec_q[x] <= beat && dec_sel && (unit == UnitW'(x));
                if (beat && dec_sel && (unit == UnitW'(x))) begin
                    m_addr_dec_q[x] <= m_idx;
                    waddr_dec_q[x]  <= addr;
                    wdata_dec_q[x]  <= in_data_i[DataTypeWidth-1:0];
                end
            end
        end
    end

    assign we_enc_o     = we_enc_q;
    assign waddr_enc_o  = waddr_enc_q;
    assign wdata_enc_o  = wdata_enc_q;
    assign we_dec_o     = we_dec_q;
    assign m_addr_dec_o = m_addr_dec_q;
    assign waddr_dec_o  = waddr_dec_q;
    assign wdata_dec_o  = wdata_dec_q;

endmodule

// File: tb/tb_halut_matmul_loader.sv
// tb/tb_halut_matmul_loader.sv - self-checking bench for halut_matmul_loader (HALUT_LOADER_ABORT_EN optional)
module tb_halut_matmul_loader;

    localparam int K = 16, C = 32, M = 32, DU = 16, DW = 16, EU = 4, EDW = 16;
    localparam int DUX = M / DU, CPE = C / EU, LW = 16;
    localparam int ENC_TOTAL = EU * CPE * K;
    localparam int DEC_TOTAL = M * C * K;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i, start_i, mode_i, in_valid_i, in_ready_o, busy_o, done_o;
    logic [LW-1:0] in_data_i;
    logic [$clog2(CPE*K)-1:0] waddr_enc_o [EU];
    logic [EDW-1:0]           wdata_enc_o [EU];
    logic                     we_enc_o    [EU];
    logic [$clog2(DU)-1:0]    m_addr_dec_o[DUX];
    logic [$clog2(C*K)-1:0]   waddr_dec_o [DUX];
    logic [DW-1:0]            wdata_dec_o [DUX];
    logic                     we_dec_o    [DUX];
`ifdef HALUT_LOADER_ABORT_EN
    logic abort_i = 1'b0;
`endif

    halut_matmul_loader #(
        .K(K), .C(C), .M(M), .DecoderUnits(DU), .DataTypeWidth(DW),
        .EncUnits(EU), .EncDataWidth(EDW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
`ifdef HALUT_LOADER_ABORT_EN
        .abort_i(abort_i),
`endif
        .start_i(start_i), .mode_i(mode_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .busy_o(busy_o), .done_o(done_o),
        .waddr_enc_o(waddr_enc_o), .wdata_enc_o(wdata_enc_o), .we_enc_o(we_enc_o),
        .m_addr_dec_o(m_addr_dec_o), .waddr_dec_o(waddr_dec_o),
        .wdata_dec_o(wdata_dec_o), .we_dec_o(we_dec_o)
    );

    typedef struct packed {
        logic dec;
        int   unit;
        int   m;
        int   addr;
        int   data;
    } wr_t;

    typedef struct {
        bit mode;
        int beat;
        int unit;
        int m;
        int addr;
    } vec_t;

    wr_t exp_q[$];
    wr_t log_a[$];
    int  total = 0, bad = 0;
    int  mism, dup_cnt, done_cnt, done_idx, done_we;
    wr_t first_exp, first_got;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic wr_t model(input bit mode, input int i);
        wr_t w;
        w.dec  = mode;
        w.data = i & 16'hffff;
        if (!mode) begin
            w.unit = i / (CPE * K);
            w.m    = 0;
            w.addr = i % (CPE * K);
        end else begin
            w.unit = i / (DU * C * K);
            w.m    = (i / (C * K)) % DU;
            w.addr = i % (C * K);
        end
        return w;
    endfunction

    function automatic int any_nonzero();
        int r = 0;
        for (int u = 0; u < EU; u++)
            if (we_enc_o[u] || waddr_enc_o[u] != 0 || wdata_enc_o[u] != 0) r = 1;
        for (int x = 0; x < DUX; x++)
            if (we_dec_o[x] || m_addr_dec_o[x] != 0 || waddr_dec_o[x] != 0 || wdata_dec_o[x] != 0) r = 1;
        if (busy_o || done_o || in_ready_o) r = 1;
        return r;
    endfunction

    task automatic reset_stats();
        exp_q.delete();
        log_a.delete();
        mism = 0; dup_cnt = 0; done_cnt = 0; done_idx = -1; done_we = 0;
    endtask

    // Write monitor: scoreboard pop/compare on every observed we.
    always @(negedge clk) begin
        int  n;
        wr_t w, e;
        n = 0;
        w = '0;
        for (int u = 0; u < EU; u++) if (we_enc_o[u]) begin
            n++;
            w.dec = 1'b0; w.unit = u; w.m = 0;
            w.addr = int'(waddr_enc_o[u]); w.data = int'(wdata_enc_o[u]);
        end
        for (int x = 0; x < DUX; x++) if (we_dec_o[x]) begin
            n++;
            w.dec = 1'b1; w.unit = x; w.m = int'(m_addr_dec_o[x]);
            w.addr = int'(waddr_dec_o[x]); w.data = int'(wdata_dec_o[x]);
        end
        if (n > 1) dup_cnt++;
        if (n == 1) begin
            log_a.push_back(w);
            if (exp_q.size() == 0) begin
                if (mism == 0) begin first_exp = '0; first_got = w; end
                mism++;
            end else begin
                e = exp_q.pop_front();
                if (e != w) begin
                    if (mism == 0) begin first_exp = e; first_got = w; end
                    mism++;
                end
            end
        end
        if (done_o) begin
            done_cnt++;
            done_idx = log_a.size();
            done_we  = n;
        end
    end

    task automatic run_load(input bit mode, input int pct, input int rst_at,
                            input int abort_at, input int poke_at, output int accepted);
        int  n_beats, i, cyc;
        bit  stop;
        n_beats = mode ? DEC_TOTAL : ENC_TOTAL;
        i = 0; cyc = 0; stop = 0;
        reset_stats();
        start_i = 1'b1; mode_i = mode;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("busy_after_start", int'(busy_o), 1);
        while (i < n_beats && !stop && cyc < n_beats * 4 + 200) begin
            in_valid_i = ($urandom_range(99) < pct);
            in_data_i  = LW'(i);
            start_i    = (poke_at >= 0 && i == poke_at);
            if (rst_at >= 0 && i == rst_at) begin
                in_valid_i = 1'b1; rst_i = 1'b1; stop = 1;
`ifdef HALUT_LOADER_ABORT_EN
            end else if (abort_at >= 0 && i == abort_at) begin
                in_valid_i = 1'b1; abort_i = 1'b1; stop = 1;
`endif
            end else if (in_valid_i && in_ready_o) begin
                exp_q.push_back(model(mode, i));
                i++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid_i = 1'b0; start_i = 1'b0; rst_i = 1'b0;
`ifdef HALUT_LOADER_ABORT_EN
        abort_i = 1'b0;
`endif
        if (!stop) chk(mode ? "dec_load_complete" : "enc_load_complete", i, n_beats);
        accepted = i;
    endtask

    task automatic finish_load(input string tag, input int n_beats);
        chk({tag, "_done_pulse"}, int'(done_o), 1);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk({tag, "_start_in_done_ignored"}, int'(busy_o), 0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_write_count"}, log_a.size(), n_beats);
        if (mism != 0)
            $display("FAIL %s_first_write: got=%h want=%h", tag, first_got, first_exp);
        chk({tag, "_sb_mismatches"}, mism, 0);
        chk({tag, "_dup_we"}, dup_cnt, 0);
        chk({tag, "_sb_leftover"}, exp_q.size(), 0);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_at_last_write"}, done_idx, n_beats);
        chk({tag, "_done_with_we"}, done_we, 1);
        chk({tag, "_idle_after"}, int'(busy_o), 0);
    endtask

    task automatic check_table(input bit mode, input vec_t tbl[$]);
        foreach (tbl[j]) begin
            if (tbl[j].mode != mode) continue;
            if (tbl[j].beat < log_a.size()) begin
                chk($sformatf("tbl_m%0d_b%0d_unit", mode, tbl[j].beat), log_a[tbl[j].beat].unit, tbl[j].unit);
                chk($sformatf("tbl_m%0d_b%0d_m", mode, tbl[j].beat), log_a[tbl[j].beat].m, tbl[j].m);
                chk($sformatf("tbl_m%0d_b%0d_addr", mode, tbl[j].beat), log_a[tbl[j].beat].addr, tbl[j].addr);
                chk($sformatf("tbl_m%0d_b%0d_data", mode, tbl[j].beat), log_a[tbl[j].beat].data, tbl[j].beat);
            end else begin
                chk($sformatf("tbl_m%0d_b%0d_present", mode, tbl[j].beat), log_a.size(), tbl[j].beat + 1);
            end
        end
    endtask

    initial begin
        vec_t tbl[$];
        int   acc;
        tbl = '{
            '{0, 0,     0, 0,  0},
            '{0, 127,   0, 0,  127},
            '{0, 128,   1, 0,  0},
            '{0, 300,   2, 0,  44},
            '{0, 511,   3, 0,  127},
            '{1, 0,     0, 0,  0},
            '{1, 511,   0, 0,  511},
            '{1, 512,   0, 1,  0},
            '{1, 8191,  0, 15, 511},
            '{1, 8192,  1, 0,  0},
            '{1, 8703,  1, 0,  511},
            '{1, 16383, 1, 15, 511}
        };

        rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
        reset_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", any_nonzero(), 0);
        rst_i = 1'b0;
        @(posedge clk); #1;
        chk("idle_not_ready", int'(in_ready_o), 0);
        chk("idle_not_busy", int'(busy_o), 0);

        run_load(1'b0, 100, -1, -1, -1, acc);
        finish_load("enc_cont", ENC_TOTAL);
        check_table(1'b0, tbl);

        run_load(1'b0, 50, -1, -1, -1, acc);
        finish_load("enc_stall", ENC_TOTAL);
        check_table(1'b0, tbl);

        run_load(1'b0, 100, 300, -1, -1, acc);
        chk("rst_mid_outputs_zero", any_nonzero(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_writes", log_a.size(), 300);
        chk("rst_mid_no_done", done_cnt, 0);
        chk("rst_mid_sb_mismatches", mism, 0);

        run_load(1'b0, 100, -1, -1, -1, acc);
        finish_load("enc_after_rst", ENC_TOTAL);
        check_table(1'b0, tbl);

        run_load(1'b1, 100, -1, -1, 100, acc);
        finish_load("dec_cont", DEC_TOTAL);
        check_table(1'b1, tbl);

`ifdef HALUT_LOADER_ABORT_EN
        run_load(1'b0, 100, -1, 10, -1, acc);
        chk("abort_busy_low", int'(busy_o), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_writes", log_a.size(), 10);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_sb_mismatches", mism, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/halut_matmul_loader.md
HALUT_MATMUL_LOADER -- requirements
Module: halut_matmul_loader

Interface
REQ-001 SHALL have parameter K, default halut_pkg::K: prototypes per codebook.
REQ-002 SHALL have parameter C, default halut_pkg::C: codebooks.
REQ-003 SHALL have parameter M, default halut_pkg::M: output columns.
REQ-004 SHALL have parameter DecoderUnits, default halut_pkg::DecoderUnits: M columns per decoder X unit.
REQ-005 SHALL have parameter DataTypeWidth, default halut_pkg::DataTypeWidth: decoder LUT word width.
REQ-006 SHALL have parameter EncUnits, default 4: encoder units.
REQ-007 SHALL have parameter EncDataWidth, default 16: FP16 threshold width.
REQ-008 SHALL have derived parameters DecUnitsX=M/DecoderUnits, CPerEncUnit=C/EncUnits, LoadWidth=max(EncDataWidth,DataTypeWidth).
REQ-009 SHALL have port clk_i, input, 1: clock; one clock, all logic on rising edge.
REQ-010 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-011 SHALL have port start_i, input, 1: start a load; sampled only in IDLE.
REQ-012 SHALL have port mode_i, input, 1: 0 = encoder thresholds, 1 = decoder LUTs; sampled with start_i.
REQ-013 SHALL have ports in_valid_i (input, 1), in_ready_o (output, 1), in_data_i (input, LoadWidth): word stream; a beat is in_valid_i & in_ready_o.
REQ-014 SHALL have ports busy_o (output, 1) and done_o (output, 1): busy while not IDLE; one-cycle completion pulse.
REQ-015 SHALL have ports waddr_enc_o[EncUnits] ($clog2(CPerEncUnit*K)), wdata_enc_o[EncUnits] (EncDataWidth), we_enc_o[EncUnits] (1): outputs, encoder threshold write ports.
REQ-016 SHALL have ports m_addr_dec_o[DecUnitsX] ($clog2(DecoderUnits)), waddr_dec_o[DecUnitsX] ($clog2(C*K)), wdata_dec_o[DecUnitsX] (DataTypeWidth), we_dec_o[DecUnitsX] (1): outputs, decoder LUT write ports.

Function
REQ-017 SHALL implement FSM IDLE, LOAD_ENC, LOAD_DEC, DONE; IDLE+start_i -> LOAD_ENC (mode 0) or LOAD_DEC (mode 1); last beat accepted -> DONE; DONE -> IDLE unconditionally.
REQ-018 SHALL drive in_ready_o=1 only in LOAD_ENC/LOAD_DEC; never in IDLE or DONE.
REQ-019 SHALL order encoder beats unit-major: beat i -> unit i/(CPerEncUnit*K), address i%(CPerEncUnit*K); total EncUnits*CPerEncUnit*K beats.
REQ-020 SHALL order decoder beats x outer, m middle, address inner: x = i/(DecoderUnits*C*K), m = (i/(C*K))%DecoderUnits, addr = i%(C*K); total M*C*K beats.
REQ-021 SHALL register write outputs: beat accepted in cycle t -> exactly one we asserted in t+1 with matching address/data (low bits of in_data_i); all other we low.
REQ-022 SHALL hold counters and issue no write when in_valid_i=0 (stall); gaps of any length tolerated.
REQ-023 SHALL pulse done_o in the DONE cycle, i.e. the same cycle as the final we; busy_o=1 in LOAD_* and DONE.
REQ-024 SHALL ignore start_i while busy_o=1.
REQ-025 SHALL use counter widths sized for M*C*K-1 with no wrap before the terminal beat; counters clear on entry to IDLE.

Reset
REQ-026 SHALL, on rst_i=1 at a clock edge, enter IDLE, clear counters, drive all we, done_o, busy_o, in_ready_o to 0 and all address/data outputs to 0.
REQ-027 SHALL, on reset mid-load, drop the pending registered write (no we next cycle) and emit no done_o.

Configuration
REQ-028 SHALL, with macro HALUT_LOADER_ABORT_EN defined, add input abort_i (1 bit): in LOAD_* it returns FSM to IDLE next cycle, accepts no beat that cycle, suppresses done_o; a write registered the previous cycle still completes.
REQ-029 SHALL, without HALUT_LOADER_ABORT_EN, omit abort_i; loads end only by completion or reset.

Structure
REQ-030 SHALL place the FSM state enum (halut_loader_state_e) in halut_pkg; K, C, M, DecoderUnits, DataTypeWidth defaults stay there.
REQ-031 SHALL use one sub-module, halut_loader_addr_gen, mapping the flat beat counter and mode to unit/m/address indices.

Verification (K=16, C=32, M=32, DecoderUnits=16, EncUnits=4: 512 enc beats, 16384 dec beats)
REQ-032 SHALL cover: start mode 0, continuous valid, data=i -> beat 128 writes unit1 addr0 data 128; done_o same cycle as unit3 addr127 write.
REQ-033 SHALL cover: start mode 1, data=i -> beat 8192 writes x=1 m=0 addr0; beat 8703 writes x=1 m=0 addr511; done_o on beat 16383 write.
REQ-034 SHALL cover: in_valid_i toggling 50% random -> identical address/data sequence, 512 writes exactly, no duplicate we.
REQ-035 SHALL cover: rst_i at beat 300 of enc load -> next cycle all outputs 0, no done_o; new start completes 512 beats from unit0 addr0.
REQ-036 SHALL cover: start_i during LOAD_DEC -> ignored, load completes normally; start_i in DONE cycle -> ignored.
REQ-037 SHALL cover, with HALUT_LOADER_ABORT_EN: abort_i at beat 10 -> 10 writes total, busy_o low next cycle, no done_o.
